text_cursor_ctrl: RTL and testbench



---
 rtl/text_cursor_ctrl.sv | 168 ++++++++++++++++
 tb/tb_text_cursor_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_cursor_ctrl.sv
// Cursor and command sequencer in front of the ASCII glyph renderer.
// Keystrokes are buffered one deep and decoded into a "draw glyph C at (x,y)"
// command. The command is held on a go/idle handshake. The cursor commits
// when the renderer reports that it is idle again.
module text_cursor_ctrl #(
  parameter int COLS        = 40,
  parameter int ROWS        = 20,
  parameter int DRAW_CYCLES = 96
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [6:0] key_ascii,
  input  logic       vga_go,
  output logic       go,
  output logic [6:0] ASCII,
  output logic [8:0] reg_x,
  output logic [8:0] reg_y,
  output logic [5:0] cur_col,
  output logic [4:0] cur_row,
  output logic       key_drop
);

  localparam logic [5:0] COL_MAX = 6'(COLS - 1);
  localparam logic [4:0] ROW_MAX = 5'(ROWS - 1);
  localparam int         CNT_W   = $clog2(DRAW_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAW_CYCLES - 1);

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_DECODE, S_ISSUE, S_RELEASE} state_t;

  state_t           r_state;
  logic             r_buf_full;
  logic [6:0]       r_buf_data;
  logic             r_key_drop;
  logic [6:0]       r_key;
  logic [5:0]       r_col, r_nxt_col;
  logic [4:0]       r_row, r_nxt_row;
  logic             r_go;
  logic [6:0]       r_ascii;
  logic [8:0]       r_x, r_y;
  logic [CNT_W-1:0] r_cnt;

  logic       w_pop;
  logic       w_is_print, w_is_bksp, w_is_enter, w_at_origin;
  logic [5:0] w_adv_col, w_ret_col, w_tgt_col;
  logic [4:0] w_adv_row, w_ret_row, w_tgt_row, w_enter_row;
  logic [8:0] w_row9, w_tgt_x, w_tgt_y;

  // The buffer drains only from IDLE, so a key arriving in that same cycle still fits.
  assign w_pop = (r_state == S_IDLE) && r_buf_full;

  // Classify the popped key and derive the neighbouring cursor cells.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    w_is_print  = (r_key >= 7'h20) && (r_key <= 7'h7E);
    w_is_bksp   = (r_key == 7'h08);
    w_is_enter  = (r_key == 7'h0D);
    w_at_origin = (r_col == 6'd0) && (r_row == 5'd0);
    w_enter_row = (r_row == ROW_MAX) ? 5'd0 : r_row + 5'd1;

    w_adv_col = r_col + 6'd1;
    w_adv_row = r_row;
    if (r_col == COL_MAX) begin
      w_adv_col = 6'd0;
      w_adv_row = w_enter_row;
    end

    w_ret_col = r_col - 6'd1;
    w_ret_row = r_row;
    if (r_col == 6'd0) begin
      w_ret_col = COL_MAX;
      w_ret_row = r_row - 5'd1;
    end

    w_tgt_col = w_is_bksp ? w_ret_col : r_col;
    w_tgt_row = w_is_bksp ? w_ret_row : r_row;
    w_row9    = {4'd0, w_tgt_row};
    w_tgt_x   = {w_tgt_col, 3'b000};
    w_tgt_y   = (w_row9 << 3) + (w_row9 << 1) + w_row9;
  end

  // Fill the single-entry buffer and flag keys that arrive while it is full.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      // NOTE: the buffer data is reset as well, so no X can reach the decode path.
      r_buf_full <= 1'b0;
      r_buf_data <= 7'd0;
      r_key_drop <= 1'b0;
    end else begin
      // NOTE: state updates use <= so every block reads values from before the edge.
      r_key_drop <= key_valid && r_buf_full && !w_pop;
      if (key_valid && (!r_buf_full || w_pop)) begin
        r_buf_full <= 1'b1;
        r_buf_data <= key_ascii;
      end else if (w_pop) begin
        r_buf_full <= 1'b0;
      end
    end
  end

  // Command sequencer: decode the key, hold the draw request, then commit the cursor.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_state   <= S_INIT;
      r_key     <= 7'd0;
      r_col     <= 6'd0;
      r_row     <= 5'd0;
      r_nxt_col <= 6'd0;
      r_nxt_row <= 5'd0;
      r_go      <= 1'b0;
      r_ascii   <= 7'd0;
      r_x       <= 9'd0;
      r_y       <= 9'd0;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        S_INIT: if (vga_go) r_state <= S_IDLE;
        S_IDLE: begin
          if (r_buf_full) begin
            r_key   <= r_buf_data;
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          r_state <= S_IDLE;
          if (w_is_print || (w_is_bksp && !w_at_origin)) begin
            r_ascii   <= w_is_print ? r_key : 7'h20;
            r_x       <= w_tgt_x;
            r_y       <= w_tgt_y;
            r_nxt_col <= w_is_print ? w_adv_col : w_ret_col;
            r_nxt_row <= w_is_print ? w_adv_row : w_ret_row;
            r_go      <= 1'b1;
            r_cnt     <= CNT_LOAD;
            r_state   <= S_ISSUE;
          end else if (w_is_enter) begin
            r_col <= 6'd0;
            r_row <= w_enter_row;
          end
        end
        S_ISSUE: begin
          if (r_cnt == '0) begin
            r_go    <= 1'b0;
            r_state <= S_RELEASE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_RELEASE: begin
          if (vga_go) begin
            r_col   <= r_nxt_col;
            r_row   <= r_nxt_row;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_INIT;
      endcase
    end
  end

  assign go       = r_go;
  assign ASCII    = r_ascii;
  assign reg_x    = r_x;
  assign reg_y    = r_y;
  assign cur_col  = r_col;
  assign cur_row  = r_row;
  assign key_drop = r_key_drop;

endmodule

// File: tb/tb_text_cursor_ctrl.sv
// Scoreboard bench for text_cursor_ctrl. The stimulus queues the expected draw
// commands. A monitor checks each go pulse against the head of the queue.
module tb_text_cursor_ctrl;

  logic       CLOCK_50 = 1'b0;
  logic       reset    = 1'b0;
  logic       key_valid = 1'b0;
  logic [6:0] key_ascii = 7'd0;
  logic       vga_go   = 1'b0;
  logic       go;
  logic [6:0] ASCII;
  logic [8:0] reg_x, reg_y;
  logic [5:0] cur_col;
  logic [4:0] cur_row;
  logic       key_drop;

  text_cursor_ctrl dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .key_valid(key_valid),
    .key_ascii(key_ascii),
    .vga_go   (vga_go),
    .go       (go),
    .ASCII    (ASCII),
    .reg_x    (reg_x),
    .reg_y    (reg_y),
    .cur_col  (cur_col),
    .cur_row  (cur_row),
    .key_drop (key_drop)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct packed {
    logic [6:0] a;
    logic [8:0] x;
    logic [8:0] y;
  } cmd_t;

  cmd_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   drop_cnt = 0;
  int   m_col = 0;
  int   m_row = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pop the expected command on each rising go and check its length and stability.
  bit   in_cmd = 1'b0;
  bit   stable;
  int   len;
  cmd_t held, e;
  always @(negedge CLOCK_50) begin
    if (!reset) begin
      in_cmd = 1'b0;
    end else if (go) begin
      if (!in_cmd) begin
        in_cmd = 1'b1;
        len    = 1;
        stable = 1'b1;
        held   = {ASCII, reg_x, reg_y};
        if (exp_q.size() == 0) begin
          check("unexpected_go", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("ascii", 32'(ASCII), 32'(e.a));
          check("reg_x", 32'(reg_x), 32'(e.x));
          check("reg_y", 32'(reg_y), 32'(e.y));
        end
      end else begin
        len++;
        if ({ASCII, reg_x, reg_y} != held) stable = 1'b0;
      end
    end else if (in_cmd) begin
      in_cmd = 1'b0;
      check("go_len", len, 96);
      check("go_stable", 32'(stable), 1);
    end
  end

  // Count key_drop pulses.
  always @(negedge CLOCK_50) if (reset && key_drop) drop_cnt++;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  task automatic send(input logic [6:0] c);
    @(posedge CLOCK_50); #1;
    key_valid = 1'b1;
    key_ascii = c;
    @(posedge CLOCK_50); #1;
    key_valid = 1'b0;
  endtask

  task automatic pulse_vga();
    @(posedge CLOCK_50); #1;
    vga_go = 1'b1;
    @(posedge CLOCK_50); #1;
    vga_go = 1'b0;
  endtask

  task automatic wait_go(input logic lvl, input int lim, input string name);
    int n = 0;
    while (go !== lvl && n < lim) begin
      @(posedge CLOCK_50); #1;
      n++;
    end
    if (go !== lvl) check(name, 32'(go), 32'(lvl));
  endtask

  task automatic finish_cmd();
    wait_go(1'b1, 20, "go_rise_timeout");
    wait_go(1'b0, 200, "go_fall_timeout");
    cycles(3);
    pulse_vga();
  endtask

  task automatic type_char(input logic [6:0] c);
    exp_q.push_back({c, 9'(m_col * 8), 9'(m_row * 11)});
    send(c);
    finish_cmd();
    if (m_col == 39) begin
      m_col = 0;
      m_row = (m_row + 1) % 20;
    end else begin
      m_col++;
    end
  endtask

  task automatic press_enter();
    send(7'h0D);
    cycles(2);
    m_col = 0;
    m_row = (m_row + 1) % 20;
  endtask

  task automatic check_cur(input string name, input int col, input int row);
    check({name, "_col"}, 32'(cur_col), col);
    check({name, "_row"}, 32'(cur_row), row);
  endtask

  initial begin
    // Reset state
    cycles(2);
    check("rst_go", 32'(go), 0);
    check("rst_ascii", 32'(ASCII), 0);
    check("rst_x", 32'(reg_x), 0);
    check("rst_y", 32'(reg_y), 0);
    check_cur("rst", 0, 0);
    check("rst_drop", 32'(key_drop), 0);
    reset = 1'b1;
    cycles(2);
    pulse_vga();

    // First key
    type_char(7'h41);
    check_cur("after_A", 1, 0);

    // Fill row 0, then wrap at the end of the row
    for (int i = 0; i < 38; i++) type_char(7'(8'h61 + i % 26));
    check_cur("at_39_0", 39, 0);
    type_char(7'h5A);
    check_cur("after_Z", 0, 1);

    // Last cell wraps to the origin
    for (int i = 0; i < 18; i++) press_enter();
    check_cur("enter_to_19", 0, 19);
    for (int i = 0; i < 39; i++) type_char(7'(8'h30 + i % 10));
    check_cur("at_39_19", 39, 19);
    exp_q.push_back({7'h51, 9'd312, 9'd209});
    send(7'h51);
    finish_cmd();
    m_col = 0; m_row = 0;
    check_cur("after_Q", 0, 0);

    // Backspace from column 0 retreats to the previous row
    for (int i = 0; i < 3; i++) press_enter();
    check_cur("at_0_3", 0, 3);
    exp_q.push_back({7'h20, 9'd312, 9'd22});
    send(7'h08);
    finish_cmd();
    m_col = 39; m_row = 2;
    check_cur("after_bksp", 39, 2);

    // Backspace at the origin does nothing
    for (int i = 0; i < 18; i++) press_enter();
    check_cur("back_origin", 0, 0);
    send(7'h08);
    cycles(6);
    check("bksp0_go", 32'(go), 0);
    check_cur("bksp0", 0, 0);

    // Enter on the last row wraps to the origin
    for (int i = 0; i < 19; i++) press_enter();
    for (int i = 0; i < 5; i++) type_char(7'h2E);
    check_cur("at_5_19", 5, 19);
    press_enter();
    check_cur("enter_wrap", 0, 0);

    // Ignored code: no command, no drop, cursor unchanged
    send(7'h1B);
    cycles(6);
    check("esc_go", 32'(go), 0);
    check("esc_drop", drop_cnt, 0);
    check_cur("esc", 0, 0);

    // Keys during ISSUE: first is buffered, second is dropped
    exp_q.push_back({7'h58, 9'd0, 9'd0});
    exp_q.push_back({7'h42, 9'd8, 9'd0});
    send(7'h58);
    wait_go(1'b1, 20, "go_rise_timeout");
    send(7'h42);
    send(7'h43);
    cycles(2);
    check("drop_count", drop_cnt, 1);
    finish_cmd();
    finish_cmd();
    check_cur("after_XB", 2, 0);

    // Reset during ISSUE
    exp_q.push_back({7'h44, 9'd16, 9'd0});
    send(7'h44);
    wait_go(1'b1, 20, "go_rise_timeout");
    cycles(10);
    @(posedge CLOCK_50); #2;
    reset = 1'b0;
    #1;
    check("reset_go", 32'(go), 0);
    check_cur("reset", 0, 0);
    cycles(3);
    reset = 1'b1;
    send(7'h45);
    cycles(20);
    check("init_no_go", 32'(go), 0);
    m_col = 0; m_row = 0;
    exp_q.push_back({7'h45, 9'd0, 9'd0});
    pulse_vga();
    finish_cmd();
    check_cur("after_E", 1, 0);

    cycles(4);
    check("queue_empty", exp_q.size(), 0);
    check("final_drops", drop_cnt, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
